// File: rtl/cache_pkg.sv
// cache_pkg: shared types, load/store size encodings and address-split helpers for data_cache.
package cache_pkg;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} cache_state_t;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   localparam int BYTE_BITS = 2;

   function automatic int word_bits(int block_words);
      return $clog2(block_words);
   endfunction

   function automatic int index_bits(int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_bits(int addr_width, int num_sets, int block_words);
      return addr_width - BYTE_BITS - $clog2(num_sets) - $clog2(block_words);
   endfunction

endpackage

// File: rtl/load_store_align.sv
// load_store_align: byte-lane enables, store lane replication and sign/zero-extended load data.
module load_store_align
   import cache_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   input  logic [31:0] store_data,
   input  logic [31:0] line_word,
   output logic [3:0]  byte_en,
   output logic [31:0] store_lanes,
   output logic [31:0] load_data
);

   logic [1:0]  lane;
   logic [31:0] shifted;
   logic        is_word;
   logic        is_half;
   logic        signed_ld;

   // Offset bits below the access size are dropped, which forces misaligned accesses aligned.
   always_comb begin
      is_word     = funct3[1:0] == LS_W[1:0];
      is_half     = funct3[1:0] == LS_H[1:0];
      signed_ld   = ~funct3[2];
      lane        = is_word ? 2'b00 : is_half ? {offset[1], 1'b0} : offset;
      byte_en     = is_word ? 4'hf : is_half ? (offset[1] ? 4'hc : 4'h3) : 4'b0001 << offset;
      store_lanes = is_word ? store_data : is_half ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
      shifted     = line_word >> {lane, 3'b000};
      load_data   = is_word ? line_word
                  : is_half ? {{16{signed_ld & shifted[15]}}, shifted[15:0]}
                  : {{24{signed_ld & shifted[7]}}, shifted[7:0]};
   end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate L1 D-cache; zero-latency hits,
// misses stall the pipeline while the FSM writes back the victim and refills word-serially.
module data_cache
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int NUM_SETS    = 64,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   input  logic                  MemWriteM,
   input  logic                  MemReadM,
   input  logic [2:0]            AddressingControlM,
   output logic [DATA_WIDTH-1:0] ReadDataM,
   output logic                  StallMemory,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);

   localparam int WB = word_bits(BLOCK_WORDS);
   localparam int IB = index_bits(NUM_SETS);
   localparam int TB = tag_bits(ADDR_WIDTH, NUM_SETS, BLOCK_WORDS);

   logic [TB-1:0]         tags  [NUM_SETS];
   logic [DATA_WIDTH-1:0] lines [NUM_SETS][BLOCK_WORDS];
   logic [NUM_SETS-1:0]   valid;
   logic [NUM_SETS-1:0]   dirty;

   cache_state_t state;
   cache_state_t next_state;
   logic [WB-1:0] cnt;
   logic [IB-1:0] miss_idx;
   logic [TB-1:0] miss_tag;

   logic [WB-1:0] word;
   logic [IB-1:0] idx;
   logic [TB-1:0] tag;
   logic          access;
   logic          hit;
   logic          store_hit;
   logic          xfer;
   logic          last;
   logic [3:0]    byte_en;
   logic [31:0]   store_lanes;
   logic [31:0]   load_data;

   assign word        = ALUResultM[WB+1:2];
   assign idx         = ALUResultM[IB+WB+1:WB+2];
   assign tag         = ALUResultM[ADDR_WIDTH-1:IB+WB+2];
   assign access      = MemReadM | MemWriteM;
   assign hit         = access && state == IDLE && valid[idx] && tags[idx] == tag;
   assign store_hit   = MemWriteM & hit;
   assign StallMemory = access & ~hit;
   assign ReadDataM   = (MemReadM && !MemWriteM && hit) ? load_data : '0;
   // Derived from state rather than mem_req so the handshake never loops through the FSM logic.
   assign xfer        = mem_ready && state != IDLE;
   assign last        = cnt == WB'(BLOCK_WORDS - 1);

   load_store_align u_align (
      .offset      (ALUResultM[1:0]),
      .funct3      (AddressingControlM),
      .store_data  (WriteDataM),
      .line_word   (lines[idx][word]),
      .byte_en     (byte_en),
      .store_lanes (store_lanes),
      .load_data   (load_data)
   );

   always_comb begin
      next_state = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state)
         IDLE:
            if (StallMemory) next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
         WRITEBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tags[miss_idx], miss_idx, cnt, 2'b00};
            mem_wdata = lines[miss_idx][cnt];
            if (xfer && last) next_state = ALLOCATE;
         end
         ALLOCATE: begin
            mem_req  = 1'b1;
            mem_addr = {miss_tag, miss_idx, cnt, 2'b00};
            if (xfer && last) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // The missing address is latched so pipeline input changes during a refill are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         valid    <= '0;
         dirty    <= '0;
         miss_idx <= '0;
         miss_tag <= '0;
      end else begin
         state <= next_state;
         cnt   <= cnt + WB'(xfer);
         if (state == IDLE && StallMemory) begin
            miss_idx <= idx;
            miss_tag <= tag;
         end
         if (store_hit) dirty[idx] <= 1'b1;
         if (state == ALLOCATE && xfer && last) begin
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == ALLOCATE && xfer) lines[miss_idx][cnt] <= mem_rdata;
      if (state == ALLOCATE && xfer && last) tags[miss_idx] <= miss_tag;
      if (store_hit)
         for (int b = 0; b < 4; b++)
            if (byte_en[b]) lines[idx][word][8*b +: 8] <= store_lanes[8*b +: 8];
   end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed, table-driven and random checks of data_cache against a flat
// byte-addressed memory model that the cache must be transparent to.
module tb_data_cache;
   import cache_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic        MemWriteM;
   logic        MemReadM;
   logic [2:0]  AddressingControlM;
   logic [31:0] ReadDataM;
   logic        StallMemory;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready;
   logic        ready_dir = 1'b1;
   logic        ready_rnd = 1'b1;
   logic        rand_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} xfer_t;
   xfer_t xlog[$];

   logic [31:0] bmem [logic [31:0]];
   logic [31:0] gm   [logic [31:0]];

   typedef struct {logic we; logic re; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd; logic [31:0] exp;} vec_t;
   vec_t vecs[$];

   data_cache dut (
      .clk(clk), .rst(rst), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .MemWriteM(MemWriteM), .MemReadM(MemReadM), .AddressingControlM(AddressingControlM),
      .ReadDataM(ReadDataM), .StallMemory(StallMemory), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;
   assign mem_ready = rand_ready ? ready_rnd : ready_dir;

   function automatic logic [31:0] init_word(logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] bword(logic [31:0] a);
      return bmem.exists(a) ? bmem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] gword(logic [31:0] a);
      return gm.exists(a) ? gm[a] : init_word(a);
   endfunction

   function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      w = gword({a[31:2], 2'b00});
      b = 8'(w >> (8 * a[1:0]));
      h = 16'(w >> (16 * a[1]));
      if (f3 == LS_B)  return {{24{b[7]}}, b};
      if (f3 == LS_BU) return {24'h0, b};
      if (f3 == LS_H)  return {{16{h[15]}}, h};
      if (f3 == LS_HU) return {16'h0, h};
      return w;
   endfunction

   function automatic void gm_store(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
      logic [31:0] wa;
      logic [31:0] w;
      wa = {a[31:2], 2'b00};
      w  = gword(wa);
      if (f3[1:0] == 2'b00) w[8*a[1:0] +: 8] = wd[7:0];
      else if (f3[1:0] == 2'b01) w[16*a[1] +: 16] = wd[15:0];
      else w = wd;
      gm[wa] = w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Backing memory: every write-back must carry the data the flat model says that word holds.
   always @(posedge clk) begin
      if (mem_req && mem_ready && !rst) begin
         xlog.push_back('{mem_we, mem_addr, mem_wdata});
         if (mem_we) begin
            chk("wb_data", mem_wdata, gword(mem_addr));
            bmem[mem_addr] = mem_wdata;
         end
      end
   end

   always @(negedge clk) begin
      mem_rdata <= bword(mem_addr);
      ready_rnd <= $urandom_range(0, 3) != 0;
   end

   task automatic do_access(input logic we, input logic re, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int stall, output logic [31:0] rd);
      MemWriteM = we; MemReadM = re; AddressingControlM = f3; ALUResultM = a; WriteDataM = wd;
      stall = 0;
      rd = '0;
      forever begin
         @(negedge clk);
         if (!StallMemory) begin
            rd = ReadDataM;
            break;
         end
         stall++;
         if (stall > 400) begin
            chk("stall_timeout", 32'(stall), 32'd400);
            break;
         end
      end
      @(posedge clk);
      #1;
      if (we && stall <= 400) gm_store(f3, a, wd);
      MemWriteM = 1'b0;
      MemReadM = 1'b0;
   endtask

   initial begin
      int          st;
      int          k;
      int          n;
      logic [31:0] rd;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp;
      logic [2:0]  f3;
      logic        we;

      rst = 1'b1;
      MemWriteM = 1'b0; MemReadM = 1'b0; AddressingControlM = LS_W; ALUResultM = '0; WriteDataM = '0;
      bmem[32'h100] = 32'hDEAD_BEEF;
      gm[32'h100]   = 32'hDEAD_BEEF;
      #3;
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_stall", 32'(StallMemory), 0);
      chk("rst_rdata", ReadDataM, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Cold load: clean miss then hit.
      xlog.delete();
      do_access(0, 1, LS_W, 32'h100, 0, st, rd);
      chk("t1_stall", 32'(st), 5);
      chk("t1_rdata", rd, 32'hDEAD_BEEF);
      chk("t1_nxfer", 32'(xlog.size()), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_addr", xlog[i].addr, 32'h100 + 32'(4 * i));
         chk("t1_we", 32'(xlog[i].we), 0);
      end

      vecs = '{
         '{0, 1, LS_B,  32'h103, 0,        32'hFFFF_FFDE},
         '{0, 1, LS_BU, 32'h103, 0,        32'h0000_00DE},
         '{0, 1, LS_H,  32'h100, 0,        32'hFFFF_BEEF},
         '{0, 1, LS_HU, 32'h102, 0,        32'h0000_DEAD},
         '{1, 0, LS_B,  32'h101, 32'h55,   32'h0},
         '{0, 1, LS_W,  32'h100, 0,        32'hDEAD_55EF},
         '{0, 1, LS_W,  32'h103, 0,        32'hDEAD_55EF},
         '{0, 1, LS_H,  32'h101, 0,        32'h0000_55EF},
         '{0, 1, LS_BU, 32'h101, 0,        32'h0000_0055}
      };
      foreach (vecs[i]) begin
         do_access(vecs[i].we, vecs[i].re, vecs[i].f3, vecs[i].addr, vecs[i].wd, st, rd);
         chk("vec_stall", 32'(st), 0);
         chk("vec_rdata", rd, vecs[i].exp);
      end

      // Conflict miss on a dirty line.
      xlog.delete();
      do_access(0, 1, LS_W, 32'h500, 0, st, rd);
      chk("t4_stall", 32'(st), 9);
      chk("t4_rdata", rd, init_word(32'h500));
      chk("t4_nxfer", 32'(xlog.size()), 8);
      chk("t4_first_wdata", xlog[0].data, 32'hDEAD_55EF);
      for (int i = 0; i < 8; i++) begin
         chk("t4_we", 32'(xlog[i].we), i < 4 ? 1 : 0);
         chk("t4_addr", xlog[i].addr, (i < 4 ? 32'h100 : 32'h500) + 32'(4 * (i % 4)));
      end

      // ready held low for three cycles in the middle of a refill.
      xlog.delete();
      MemReadM = 1'b1; AddressingControlM = LS_W; ALUResultM = 32'h1200;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (xlog.size() < 2 && n < 50);
      chk("t5_reach", 32'(xlog.size()), 2);
      ready_dir = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t5_req_held", 32'(mem_req), 1);
         chk("t5_addr_held", mem_addr, 32'h1208);
         chk("t5_cnt_frozen", 32'(xlog.size()), 2);
      end
      ready_dir = 1'b1;
      n = 0;
      while (StallMemory && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t5_rdata", ReadDataM, init_word(32'h1200));
      chk("t5_nxfer", 32'(xlog.size()), 4);
      chk("t5_last_addr", xlog[3].addr, 32'h120C);
      @(posedge clk);
      #1;
      MemReadM = 1'b0;

      // Reset in the middle of a write-back.
      do_access(1, 0, LS_W, 32'h500, 32'h1234_5678, st, rd);
      chk("t6_store_stall", 32'(st), 0);
      xlog.delete();
      MemReadM = 1'b1; AddressingControlM = LS_W; ALUResultM = 32'h100;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (xlog.size() < 2 && n < 50);
      chk("t6_wb_mode", 32'(mem_we), 1);
      rst = 1'b1;
      #1;
      chk("t6_req_drop", 32'(mem_req), 0);
      chk("t6_we_drop", 32'(mem_we), 0);
      chk("t6_addr_zero", mem_addr, 0);
      MemReadM = 1'b0;
      #1;
      chk("t6_no_access_stall", 32'(StallMemory), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      gm = bmem;
      xlog.delete();
      do_access(0, 1, LS_W, 32'h100, 0, st, rd);
      chk("t6_refill_stall", 32'(st), 5);
      chk("t6_rdata", rd, 32'hDEAD_55EF);
      chk("t6_nxfer", 32'(xlog.size()), 4);
      chk("t6_clean", 32'(xlog[0].we), 0);

      // Random traffic over a few conflicting lines with random ready.
      rand_ready = 1'b1;
      for (int r = 0; r < 400; r++) begin
         k  = $urandom_range(0, 4);
         f3 = k == 0 ? LS_B : k == 1 ? LS_H : k == 2 ? LS_W : k == 3 ? LS_BU : LS_HU;
         we = ($urandom_range(0, 2) == 0) && !f3[2];
         a  = 32'h0001_0000 + $urandom_range(0, 2) * 32'h400 + $urandom_range(0, 3) * 16 + $urandom_range(0, 15);
         wd = $urandom;
         exp = we ? 32'h0 : model_load(f3, a);
         do_access(we, !we, f3, a, wd, st, rd);
         chk(we ? "rnd_store_rdata" : "rnd_load", rd, exp);
      end
      rand_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
